cc_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing one external bidirectional data bus among NUM_REQ requesters.

---
 rtl/cc_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_cc_bus_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_bus_arbiter.sv
// rtl/cc_bus_arbiter.sv - round-robin arbiter for a shared bidirectional data bus
//
// Grants one of NUM_REQ requesters at a time. Each tenure is capped at MAX_HOLD
// cycles. At least TURNAROUND idle cycles separate two owners. The bus pin bank
// direction is driven from the direction the owner requested at grant time.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   req         in   per-requester request, held for the whole access
//   wr          in   per-requester direction, 1 = requester drives the bus
//   grant       out  registered one-hot grant (or zero)
//   grant_valid out  registered OR of grant
//   grant_idx   out  index of the current owner, or of the last owner while idle
//   bus_sel_in  out  pin bank direction, 1 = tri-state/input, 0 = drive
//   busy        out  high while in GRANT or TURN
module cc_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   wr,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 grant_valid,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 bus_sel_in,
    output logic                 busy
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_WIDTH-1:0] last_owner_q, last_owner_d;
    logic                 bus_sel_q, bus_sel_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
    logic [TW-1:0]        turn_cnt_q, turn_cnt_d;

    // Round-robin pick: first requester after last_owner, wrapping at NUM_REQ.
    // The previous owner is examined last, so a preempted owner only wins when
    // nobody else is asking.
    logic                 win_found;
    logic [IDX_WIDTH-1:0] win_idx;
    logic [IDX_WIDTH-1:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = last_owner_q;
        cand      = last_owner_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (cand == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : cand + IDX_WIDTH'(1);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        last_owner_d  = last_owner_q;
        bus_sel_d     = bus_sel_q;
        hold_cnt_d    = hold_cnt_q;
        turn_cnt_d    = turn_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d       = ST_GRANT;
                    grant_d       = NUM_REQ'(1) << win_idx;
                    grant_valid_d = 1'b1;
                    grant_idx_d   = win_idx;
                    last_owner_d  = win_idx;
                    // Direction is captured once; later wr changes are ignored.
                    bus_sel_d     = ~wr[win_idx];
                    hold_cnt_d    = '0;
                end
            end
            ST_GRANT: begin
                hold_cnt_d = hold_cnt_q + HW'(1);
                if (!req[grant_idx_q] || hold_cnt_q == HW'(MAX_HOLD - 1)) begin
                    state_d       = ST_TURN;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    bus_sel_d     = 1'b1;
                    turn_cnt_d    = '0;
                end
            end
            ST_TURN: begin
                turn_cnt_d = turn_cnt_q + TW'(1);
                if (turn_cnt_q == TW'(TURNAROUND - 1)) begin
                    if (win_found) begin
                        state_d       = ST_GRANT;
                        grant_d       = NUM_REQ'(1) << win_idx;
                        grant_valid_d = 1'b1;
                        grant_idx_d   = win_idx;
                        last_owner_d  = win_idx;
                        bus_sel_d     = ~wr[win_idx];
                        hold_cnt_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d       = ST_IDLE;
                grant_d       = '0;
                grant_valid_d = 1'b0;
                bus_sel_d     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            // Starting one behind requester 0 makes req[0] the first winner.
            last_owner_q  <= IDX_WIDTH'(NUM_REQ - 1);
            bus_sel_q     <= 1'b1;
            hold_cnt_q    <= '0;
            turn_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            last_owner_q  <= last_owner_d;
            bus_sel_q     <= bus_sel_d;
            hold_cnt_q    <= hold_cnt_d;
            turn_cnt_q    <= turn_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign bus_sel_in  = bus_sel_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cc_bus_arbiter.sv
// tb/tb_cc_bus_arbiter.sv - directed and random bench for cc_bus_arbiter
module tb_cc_bus_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] wr;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       bus_sel_in;
    logic       busy;

    int checks;
    int errors;

    cc_bus_arbiter #(
        .NUM_REQ(4), .IDX_WIDTH(2), .MAX_HOLD(8), .TURNAROUND(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .wr(wr),
        .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .bus_sel_in(bus_sel_in), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req     = 4'b0000;
        wr      = 4'b0000;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        req     = 4'b0000;
        wr      = 4'b0000;
        reset_n = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0 ||
            bus_sel_in !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got g=%b v=%b i=%0d s=%b b=%b exp g=0000 v=0 i=0 s=1 b=0",
                     grant, grant_valid, grant_idx, bus_sel_in, busy);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req got g=%b b=%b exp g=0000 b=0", grant, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        wr  = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100 || grant_valid !== 1'b1 || grant_idx !== 2'd2 ||
            bus_sel_in !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got g=%b v=%b i=%0d s=%b b=%b exp g=0100 v=1 i=2 s=0 b=1",
                     grant, grant_valid, grant_idx, bus_sel_in, busy);
        end
        req = 4'b0000;
        step();
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || bus_sel_in !== 1'b1 ||
            busy !== 1'b1 || grant_idx !== 2'd2) begin
            errors++;
            $display("FAIL single_release got g=%b v=%b s=%b b=%b i=%0d exp g=0000 v=0 s=1 b=1 i=2",
                     grant, grant_valid, bus_sel_in, busy, grant_idx);
        end
        step();
        checks++;
        if (busy !== 1'b0 || grant_idx !== 2'd2) begin
            errors++;
            $display("FAIL single_idle got b=%b i=%0d exp b=0 i=2", busy, grant_idx);
        end
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111;
        wr  = 4'b0000;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (grant !== (4'b0001 << order[n]) || grant_idx !== 2'(order[n])) begin
                errors++;
                $display("FAIL rr_grant[%0d] got g=%b i=%0d exp owner %0d", n, grant, grant_idx, order[n]);
            end
            step();
            checks++;
            if (grant !== (4'b0001 << order[n])) begin
                errors++;
                $display("FAIL rr_hold[%0d] got g=%b exp owner %0d", n, grant, order[n]);
            end
            req[order[n]] = 1'b0;
            step();
            checks++;
            if (grant !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL rr_gap[%0d] got g=%b b=%b exp g=0000 b=1", n, grant, busy);
            end
            req[order[n]] = 1'b1;
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_max_hold();
        do_reset();
        req = 4'b0010;
        for (int n = 0; n < 8; n++) begin
            step();
            checks++;
            if (grant !== 4'b0010) begin
                errors++;
                $display("FAIL hold_cycle[%0d] got g=%b exp 0010", n, grant);
            end
        end
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_preempt got g=%b b=%b exp g=0000 b=1", grant, busy);
        end
        step();
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL hold_regrant_sole got g=%b exp 0010", grant);
        end
        req = 4'b1010;
        for (int n = 1; n < 8; n++) begin
            step();
        end
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL hold_second_tenure got g=%b exp 0010", grant);
        end
        step();
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL hold_second_preempt got g=%b exp 0000", grant);
        end
        step();
        checks++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
            errors++;
            $display("FAIL hold_rr_to_3 got g=%b i=%0d exp g=1000 i=3", grant, grant_idx);
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_wr_latch();
        do_reset();
        req = 4'b0001;
        wr  = 4'b0000;
        step();
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (bus_sel_in !== 1'b1 || grant !== 4'b0001) begin
                errors++;
                $display("FAIL wr_ignored[%0d] got s=%b g=%b exp s=1 g=0001", n, bus_sel_in, grant);
            end
            wr[0] = ~wr[0];
            step();
        end
        req = 4'b0000;
        step();
        step();
        req = 4'b0010;
        wr  = 4'b0010;
        step();
        wr = 4'b0000;
        step();
        checks++;
        if (bus_sel_in !== 1'b0 || grant !== 4'b0010) begin
            errors++;
            $display("FAIL wr_drive_held got s=%b g=%b exp s=0 g=0010", bus_sel_in, grant);
        end
        req = 4'b0000;
        step();
        checks++;
        if (bus_sel_in !== 1'b1) begin
            errors++;
            $display("FAIL wr_release got s=%b exp 1", bus_sel_in);
        end
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        wr  = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100 || bus_sel_in !== 1'b0) begin
            errors++;
            $display("FAIL areset_pre got g=%b s=%b exp g=0100 s=0", grant, bus_sel_in);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || bus_sel_in !== 1'b1 ||
            busy !== 1'b0 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL areset_immediate got g=%b v=%b s=%b b=%b i=%0d exp g=0000 v=0 s=1 b=0 i=0",
                     grant, grant_valid, bus_sel_in, busy, grant_idx);
        end
        req = 4'b0101;
        #2;
        reset_n = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL areset_priority got g=%b i=%0d exp g=0001 i=0", grant, grant_idx);
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_random();
        int         tenure;
        int         gap;
        bit         seen;
        logic       prev_gv;
        logic [3:0] prev_g;
        tenure  = 0;
        gap     = 0;
        seen    = 1'b0;
        prev_gv = 1'b0;
        prev_g  = 4'b0000;
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            wr = 4'($urandom);
            step();
            checks++;
            if ((grant & (grant - 4'b0001)) !== 4'b0000) begin
                errors++;
                $display("FAIL rnd_onehot cycle %0d got g=%b exp one-hot or zero", n, grant);
            end
            checks++;
            if (bus_sel_in === 1'b0 && grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL rnd_drive_ungranted cycle %0d got s=0 v=%b exp v=1", n, grant_valid);
            end
            checks++;
            if (grant_valid !== (|grant)) begin
                errors++;
                $display("FAIL rnd_valid cycle %0d got v=%b exp %b", n, grant_valid, |grant);
            end
            if (grant_valid) begin
                if (prev_gv && grant == prev_g) begin
                    tenure++;
                end else begin
                    if (prev_gv) begin
                        checks++;
                        errors++;
                        $display("FAIL rnd_no_gap cycle %0d got g=%b after %b exp idle gap", n, grant, prev_g);
                    end else if (seen) begin
                        checks++;
                        if (gap < 1) begin
                            errors++;
                            $display("FAIL rnd_gap cycle %0d got %0d exp >=1", n, gap);
                        end
                    end
                    tenure = 1;
                end
                seen = 1'b1;
                gap  = 0;
                checks++;
                if (tenure > 8) begin
                    errors++;
                    $display("FAIL rnd_tenure cycle %0d got %0d exp <=8", n, tenure);
                end
            end else begin
                gap++;
            end
            prev_gv = grant_valid;
            prev_g  = grant;
        end
        req = 4'b0000;
        step();
        step();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        req     = 4'b0000;
        wr      = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_max_hold();
        test_wr_latch();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
